// File: rtl/ahb_rom_rd_master.sv
`default_nettype none
// ============================================================================
// ahb_rom_rd_master : AHB-Lite pipelined burst reader from the boot ROM into a
// 2-word valid/ready stream buffer. Optional checksum: `ROM_RD_CHECKSUM_EN.
// Revision 1.0
// ============================================================================
module ahb_rom_rd_master #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [12:0] base_addr,
  input  logic [11:0] len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        HSEL,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [12:0] HADDR,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t      state, state_nxt;
  logic [10:0] addr;
  logic [11:0] issue_cnt, recv_cnt;
  logic        inflight, hold, prev_addr_done, rej_q;
  logic [1:0]  trans, trans_q;
  logic        accept, reject;
  logic        pop, push, addr_done, issue_ok;
  logic [12:0] end_word;
  logic [2:0]  occ;

  logic [31:0] buf_mem [FIFO_DEPTH];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  entries;

  logic        unused_bits;
  assign unused_bits = ^base_addr[1:0];

  assign pop       = m_valid & m_ready;
  assign push      = inflight & HREADY;
  assign addr_done = trans[1] & HREADY;
  assign end_word  = {2'b00, base_addr[12:2]} + {1'b0, len};
  // Words already committed (buffered or in a data phase) after this cycle's pop.
  assign occ       = {1'b0, entries} + {2'b00, inflight} - {2'b00, pop};
  assign issue_ok  = (state == S_RUN) && (issue_cnt != 12'd0) && (occ < 3'(FIFO_DEPTH));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    trans     = TR_IDLE;
    // A stalled address phase must be presented unchanged until the slave takes it.
    if (hold)
      trans = trans_q;
    else if (issue_ok)
      trans = prev_addr_done ? TR_SEQ : TR_NONSEQ;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == 12'd0) begin
            state_nxt = S_DONE;
          end else if (end_word > 13'd2048) begin
            state_nxt = S_DONE;
            reject    = 1'b1;
          end else begin
            state_nxt = S_RUN;
            accept    = 1'b1;
          end
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (addr_done && (issue_cnt == 12'd1))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if ((recv_cnt == 12'd0) || (push && (recv_cnt == 12'd1)))
          state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr           <= '0;
      issue_cnt      <= '0;
      recv_cnt       <= '0;
      inflight       <= 1'b0;
      hold           <= 1'b0;
      prev_addr_done <= 1'b0;
      trans_q        <= TR_IDLE;
      rej_q          <= 1'b0;
    end else begin
      trans_q        <= trans;
      hold           <= trans[1] & ~HREADY;
      prev_addr_done <= addr_done;
      if (HREADY)
        inflight <= trans[1];
      if ((state == S_IDLE) && start)
        rej_q <= reject;
      if (accept) begin
        addr      <= base_addr[12:2];
        issue_cnt <= len;
        recv_cnt  <= len;
      end else begin
        if (addr_done) begin
          addr      <= addr + 11'd1;
          issue_cnt <= issue_cnt - 12'd1;
        end
        if (push)
          recv_cnt <= recv_cnt - 12'd1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        buf_mem[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      entries <= '0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= HRDATA;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      entries <= entries + {1'b0, push} - {1'b0, pop};
    end
  end

  assign m_valid = (entries != 2'd0);
  assign m_data  = buf_mem[rd_ptr];
  assign err     = done & rej_q;
  assign HTRANS  = trans;
  assign HSEL    = trans[1];
  assign HWRITE  = 1'b0;
  assign HADDR   = {addr, 2'b00};

`ifdef ROM_RD_CHECKSUM_EN
  logic [31:0] sum;
  always_ff @(posedge HCLK) begin
    if (!HRESETn)  sum <= '0;
    else if (accept) sum <= '0;
    else if (pop)    sum <= sum + m_data;
  end
  assign checksum = sum;
`else
  assign checksum = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_rom_rd_master.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for ahb_rom_rd_master with a behavioural ROM slave.
module tb_ahb_rom_rd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic [12:0] base_addr = '0;
  logic [11:0] len = '0;
  logic        HREADY = 1'b1;
  logic        m_ready = 1'b1;
  logic        busy, done, err, HSEL, HWRITE, m_valid;
  logic [1:0]  HTRANS;
  logic [12:0] HADDR;
  logic [31:0] HRDATA, m_data, checksum;

  ahb_rom_rd_master #(.FIFO_DEPTH(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .err(err), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HADDR(HADDR), .HREADY(HREADY), .HRDATA(HRDATA), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .checksum(checksum)
  );

  always #5 HCLK = ~HCLK;

  // ROM slave: data phase follows an accepted address phase; junk outside valid data cycles.
  logic [31:0] rom [2048];
  logic        dp_valid = 1'b0;
  logic [10:0] dp_addr = '0;
  always @(posedge HCLK) begin
    if (!HRESETn) dp_valid <= 1'b0;
    else if (HREADY) begin
      dp_valid <= HSEL && HTRANS[1];
      dp_addr  <= HADDR[12:2];
    end
  end
  assign HRDATA = (dp_valid && HREADY) ? rom[dp_addr] : 32'hDEAD_BEEF;

  logic [12:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  logic        exp_done_q [$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int hr_mode = 0, mr_mode = 0, force_low = 0;
  int done_cnt = 0, done_mark = 0, pop_cnt = 0, comp_cnt = 0;
  logic [31:0] pop_sum = '0, sum_base = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    cyc++;
    start = 1'b0;
    if (force_low > 0) begin
      HREADY = 1'b0;
      force_low--;
    end else
      HREADY = (hr_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    case (mr_mode)
      0: m_ready = 1'b1;
      1: m_ready = ($urandom_range(0, 1) == 1);
      2: m_ready = (((cyc / 2) % 2) == 1);
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic smp();
    @(negedge HCLK);
    #1;
  endtask

  // Reference model: expected bus addresses, stream words and done/err outcome.
  task automatic request(input logic [12:0] b, input int l);
    int w;
    w = int'(b[12:2]);
    start     = 1'b1;
    base_addr = b;
    len       = 12'(l);
    done_mark = done_cnt;
    if (l == 0)
      exp_done_q.push_back(1'b0);
    else if (w + l > 2048)
      exp_done_q.push_back(1'b1);
    else begin
      sum_base = pop_sum;
      for (int i = 0; i < l; i++) begin
        exp_addr_q.push_back(13'((w + i) * 4));
        exp_data_q.push_back(rom[w + i]);
      end
      exp_done_q.push_back(1'b0);
    end
  endtask

  task automatic finish_req(input string nm);
    logic [31:0] exp_ck;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt > done_mark) break;
      tick(); smp();
    end
    chk({nm, " done_seen"}, 32'(done_cnt > done_mark), 1);
    for (int i = 0; i < 3000; i++) begin
      if (!m_valid) break;
      tick(); smp();
    end
    chk({nm, " drained"}, 32'(m_valid), 0);
    chk({nm, " words_left"}, exp_data_q.size(), 0);
    chk({nm, " addrs_left"}, exp_addr_q.size(), 0);
    tick(); smp();
`ifdef ROM_RD_CHECKSUM_EN
    exp_ck = pop_sum - sum_base;
`else
    exp_ck = 32'd0;
`endif
    chk({nm, " checksum"}, checksum, exp_ck);
  endtask

  task automatic reset_values(input string nm);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " done"}, 32'(done), 0);
    chk({nm, " err"}, 32'(err), 0);
    chk({nm, " HTRANS"}, 32'(HTRANS), 0);
    chk({nm, " HSEL"}, 32'(HSEL), 0);
    chk({nm, " HADDR"}, 32'(HADDR), 0);
    chk({nm, " m_valid"}, 32'(m_valid), 0);
    chk({nm, " m_data"}, m_data, 0);
    chk({nm, " checksum"}, checksum, 0);
  endtask

  // Monitor: bus protocol, stream words and done/err against the scoreboard queues.
  logic        prev_hold = 1'b0, prev_comp = 1'b0, prev_stall = 1'b0;
  logic [1:0]  prev_tr = '0;
  logic [12:0] prev_ad = '0;
  logic [31:0] prev_md = '0;
  logic        mon_act, mon_pp;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_done_q.delete();
      prev_hold = 1'b0; prev_comp = 1'b0; prev_stall = 1'b0;
      comp_cnt = 0; pop_cnt = 0; pop_sum = '0;
    end else begin
      mon_act = HTRANS[1];
      mon_pp  = m_valid & m_ready;
      chk("hsel_vs_htrans", 32'(HSEL), 32'(HTRANS[1]));
      chk("hwrite", 32'(HWRITE), 0);
      if (prev_hold) begin
        chk("hold_haddr", 32'(HADDR), 32'(prev_ad));
        chk("hold_htrans", 32'(HTRANS), 32'(prev_tr));
      end else if (mon_act)
        chk("htrans_type", 32'(HTRANS), prev_comp ? 32'd3 : 32'd2);
      chk("occupancy_le2", 32'((comp_cnt + int'(mon_act) - pop_cnt - int'(mon_pp)) <= 2), 1);
      if (mon_act && HREADY) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_addr_phase: got HADDR %h expected none", HADDR);
        end else
          chk("haddr", 32'(HADDR), 32'(exp_addr_q.pop_front()));
        comp_cnt++;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", m_data, prev_md);
      end
      if (mon_pp) begin
        if (exp_data_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_word: got %h expected none", m_data);
        end else begin
          prev_md = exp_data_q.pop_front();
          chk("m_data", m_data, prev_md);
          pop_sum = pop_sum + prev_md;
        end
        pop_cnt++;
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else
          chk("done_err", 32'(err), 32'(exp_done_q.pop_front()));
        done_cnt++;
      end else
        chk("err_without_done", 32'(err), 0);
      prev_hold  = mon_act & ~HREADY;
      prev_comp  = mon_act & HREADY;
      prev_tr    = HTRANS;
      prev_ad    = HADDR;
      prev_stall = m_valid & ~m_ready;
      prev_md    = m_data;
    end
  end

  logic [1:0]  tr_log [7];
  logic [12:0] ad_log [7];
  logic        mv_log [7];
  logic        dn_log [7];

  initial begin
    int p0;
    for (int i = 0; i < 2048; i++) rom[i] = $urandom;
    for (int i = 0; i < 4; i++) rom[64 + i] = 32'hA5A5_0000 + 32'(i);
    rom[16] = 32'hFFFF_FFFF;
    rom[17] = 32'h0000_0002;
    repeat (3) tick();
    HRESETn = 1'b1;
    smp();
    reset_values("por");

    // Basic burst with cycle-exact timing.
    request(13'h100, 4);
    for (int c = 1; c <= 6; c++) begin
      tick(); smp();
      tr_log[c] = HTRANS; ad_log[c] = HADDR; mv_log[c] = m_valid; dn_log[c] = done;
    end
    chk("basic c1 htrans", 32'(tr_log[1]), 2);
    for (int c = 2; c <= 4; c++) chk("basic seq htrans", 32'(tr_log[c]), 3);
    chk("basic c5 htrans", 32'(tr_log[5]), 0);
    for (int c = 1; c <= 4; c++) chk("basic haddr", 32'(ad_log[c]), 32'h100 + 32'(4 * (c - 1)));
    chk("basic c2 m_valid", 32'(mv_log[2]), 0);
    chk("basic c3 m_valid", 32'(mv_log[3]), 1);
    chk("basic c5 done", 32'(dn_log[5]), 0);
    chk("basic c6 done", 32'(dn_log[6]), 1);
    finish_req("basic");

    // Wait states on the second address phase.
    request(13'h200, 4);
    tick(); smp();
    chk("ws c1 htrans", 32'(HTRANS), 2);
    force_low = 3;
    for (int k = 0; k < 3; k++) begin
      tick(); smp();
      chk("ws haddr", 32'(HADDR), 32'h204);
      chk("ws htrans", 32'(HTRANS), 3);
      chk("ws no_capture", 32'(m_valid), 0);
    end
    finish_req("waitstate");

    // Boundaries.
    request(13'h0, 0);
    tick(); smp();
    chk("len0 done", 32'(done), 1);
    chk("len0 htrans", 32'(HTRANS), 0);
    chk("len0 busy", 32'(busy), 0);
    finish_req("len0");
    request(13'h1FFC, 1);
    finish_req("top_len1");
    request(13'h1FFC, 2);
    tick(); smp();
    chk("range done", 32'(done), 1);
    chk("range err", 32'(err), 1);
    finish_req("range_err");

    // Backpressure with an ignored start while busy.
    mr_mode = 2;
    request(13'h300, 10);
    repeat (3) begin tick(); smp(); end
    chk("busy_mid", 32'(busy), 1);
    start = 1'b1; base_addr = 13'h0; len = 12'd5;
    finish_req("ignored_start");
    request(13'(4 * $urandom_range(0, 2000)), 8);
    finish_req("backpressure");

    // Checksum wrap.
    mr_mode = 1;
    request(13'h40, 2);
    finish_req("checksum");

    // Randomized traffic including near-top and out-of-range requests.
    hr_mode = 1;
    for (int t = 0; t < 14; t++) begin
      int w, l;
      w = (t % 4 == 0) ? 2047 - $urandom_range(0, 24) : $urandom_range(0, 2047);
      l = $urandom_range(0, 40);
      request(13'(w * 4 + $urandom_range(0, 3)), l);
      finish_req("random");
    end

    // Reset in the middle of a 16-word burst.
    hr_mode = 0; mr_mode = 0;
    request(13'(4 * $urandom_range(0, 2032)), 16);
    p0 = pop_cnt;
    for (int i = 0; i < 200; i++) begin
      if (pop_cnt >= p0 + 3) break;
      tick();
    end
    chk("rst three_words", 32'(pop_cnt >= p0 + 3), 1);
    HRESETn  = 1'b0;
    sum_base = '0;
    tick();
    HRESETn = 1'b1;
    smp();
    reset_values("midrst");
    request(13'h80, 2);
    finish_req("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ahb_rom_rd_master.md
# ahb_rom_rd_master

AHB-Lite read-only master that fetches a contiguous block of 32-bit words from the boot ROM slave and delivers them on a valid/ready stream. It sits directly upstream of the ROM AHB slave, drives its address/control inputs, and consumes its `HRDATA`. Address and data phases are fully pipelined, giving one word per cycle when the slave and sink are both ready. A 2-entry output buffer absorbs sink backpressure.

## Interface
- `FIFO_DEPTH`, 2: output buffer depth in words; fixed at 2, no other value supported.
- `HCLK` in 1: clock.
- `HRESETn` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request; sampled only while idle.
- `base_addr` in 13: byte address of first word; bits [1:0] ignored.
- `len` in 12: word count, 0..2048.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last word is pushed to the buffer, or after a zero-length or rejected request.
- `err` out 1: one-cycle pulse with `done` when the request is rejected.
- `HSEL` out 1: equals `HTRANS[1]`.
- `HTRANS` out 2: IDLE=00, NONSEQ=10, SEQ=11.
- `HWRITE` out 1: constant 0.
- `HADDR` out 13: word-aligned, bits [1:0] always 00.
- `HREADY` in 1: bus ready, fed back from the slave.
- `HRDATA` in 32: read data.
- `m_valid` out 1: stream valid.
- `m_data` out 32: stream word, head of the buffer.
- `m_ready` in 1: sink ready.
- `checksum` out 32: see Configuration.

## Operation
- **Reset values:** `busy`=0, `done`=0, `err`=0, `HTRANS`=00, `HSEL`=0, `HADDR`=0, `m_valid`=0, `m_data`=0, `checksum`=0. Buffer is emptied and all counters are cleared.
- **Reset mid-transfer:** the same reset values apply. Any pending data phase is abandoned. `HTRANS` is IDLE in the first cycle after reset.
- **States:**
  - IDLE:
    - `start`=1 with `len`=0 → DONE.
    - `start`=1 with `base_addr[12:2]`+`len` > 2048 → DONE with `err`=1.
    - Otherwise → RUN. Latch `addr` = `base_addr[12:2]`, `issue_cnt` = `len`, `recv_cnt` = `len`.
  - RUN:
    - Issues address phases while `issue_cnt` > 0.
    - Moves to DRAIN when the last address phase completes (`HREADY`=1 with `issue_cnt`=1).
  - DRAIN:
    - `HTRANS`=IDLE.
    - Waits until `recv_cnt` reaches 0, then → DONE.
  - DONE: `done`=1 for one cycle, `busy`=0, then → IDLE.
- **Ignored `start`:** while not IDLE, `start` is ignored.
- **Issue condition** (all must hold): RUN, `issue_cnt` > 0, and `entries` + `inflight` − `pop` < 2.
  - `pop` = `m_valid` & `m_ready`.
  - `inflight` = 1 when a data phase is outstanding.
- **`HTRANS` encoding:**
  - NONSEQ for the first transfer and for any transfer following an IDLE cycle.
  - SEQ when the previous cycle was a completed address phase.
  - IDLE when the issue condition fails.
- **Address phase completion:** completes when `HREADY`=1, then `addr`++ and `issue_cnt`--.
  - If `HREADY`=0, `HADDR` and `HTRANS` are held unchanged.
- **Data capture:** `HRDATA` is captured on the first `HREADY`=1 edge of a data phase. It is pushed to the buffer and `recv_cnt`--.
  - Push and pop in the same cycle are allowed.
  - The issue rule guarantees the buffer never overflows; overflow is a design bug.
- **Address range:** `addr` never wraps; the range is checked at start.

## Timing
- `start` is sampled at edge 0. First NONSEQ is driven in cycle 1 with `HADDR` = `base_addr` & ~3. Its data phase is cycle 2, and `m_valid`=1 from cycle 3.
- **Latency:** 3 cycles from `start` to first `m_valid`.
- **Throughput:** 1 word per cycle with `HREADY`=1 and `m_ready`=1.
- **`done`:** pulses the cycle after the last push.
- **Buffer contents after `done`:** the buffer may still hold up to 2 words, which drain normally.
- **`busy` vs. stream:** `busy` does not wait for the stream to empty.
- **Backpressure:** with `m_ready`=0, at most 2 words are buffered and at most 0 are outstanding beyond that; `HTRANS` goes IDLE.
- **Stream hold:** `m_data` is stable while `m_valid`=1 and `m_ready`=0.

## Configuration
- Macro: `ROM_RD_CHECKSUM_EN`.
- **Defined:**
  - `checksum` is a 32-bit modulo-2^32 sum of every word popped from the stream.
  - It is cleared on an accepted `start` and on reset.
  - It is final one cycle after the last pop.
- **Undefined:** `checksum` is tied to 0 and no adder is built.

## Test plan
- **Basic burst:** `base_addr`=0x100, `len`=4, `m_ready`=1, ROM word i = 0xA5A50000+i.
  - HADDR sequence: 0x100, 0x104, 0x108, 0x10C.
  - HTRANS sequence: NONSEQ, SEQ, SEQ, SEQ.
  - Stream: 4 words in order, first word at cycle 3, `done` one cycle after the fourth push.
- **Backpressure:** `len`=8, `m_ready` toggled 0/1 every 2 cycles.
  - No word lost or duplicated.
  - `HTRANS` IDLE whenever `entries` + `inflight` − `pop` would reach 2.
  - The next issue after an IDLE gap is NONSEQ.
- **Wait states:** `HREADY` low for 3 cycles during the second address phase.
  - `HADDR`=0x104 and `HTRANS`=SEQ are held throughout.
  - Data is captured only on `HREADY`=1.
- **Boundaries:**
  - `len`=0 → `done` at cycle 1, no bus activity.
  - `base_addr`=0x1FFC, `len`=1 → accepted.
  - `base_addr`=0x1FFC, `len`=2 → `done`+`err`, no bus activity.
  - `start` while `busy` → ignored.
- **Reset mid-operation:** `HRESETn`=0 for 1 cycle after 3 words of a 16-word burst.
  - All outputs return to reset values.
  - A new `start` with `len`=2 completes correctly.
- **Checksum (`ROM_RD_CHECKSUM_EN` defined):** words 0xFFFFFFFF, 0x00000002 → `checksum`=0x00000001.
  - With the macro undefined, `checksum` stays 0.
